// File: rtl/light_countdown.sv
// Dual-direction traffic-light countdown: each direction loads its phase length on a
// lamp change, counts down in BCD once per second, and is shown on a 4-digit scanned display.
module light_countdown #(
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter int GREEN_SEC  = 25,
    parameter int YELLOW_SEC = 5,
    parameter int RED_SEC    = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Red1,
    input  logic       Yellow1,
    input  logic       Green1,
    input  logic       Red2,
    input  logic       Yellow2,
    input  logic       Green2,
    output logic [7:0] Cnt1,
    output logic [7:0] Cnt2,
    output logic [3:0] AN,
    output logic [6:0] SEG
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    function automatic logic [7:0] to_bcd(input int secs);
        return {4'(secs / 10), 4'(secs % 10)};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    localparam logic [7:0] RED_BCD    = to_bcd(RED_SEC);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_SEC);
    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_SEC);

    logic [1:0][2:0] lamps;
    logic [1:0][7:0] cnt;
    logic [1:0]      valid_q;

    assign lamps[0] = {Red1, Yellow1, Green1};
    assign lamps[1] = {Red2, Yellow2, Green2};

    // Free-running one-second tick; deliberately not realigned on loads.
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge CLK) begin
        if (!RST)
            tick_cnt_reg <= '0;
        else if (tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            logic [2:0] prev_reg;
            logic [7:0] cnt_reg;
            logic [7:0] cnt_next;
            logic [7:0] load_val;
            logic       valid;
            logic       load;
            logic       valid_reg;

            always_comb begin
                valid = (lamps[gi] == 3'b100) || (lamps[gi] == 3'b010) || (lamps[gi] == 3'b001);
                load  = valid && (lamps[gi] != prev_reg);
                case (lamps[gi])
                    3'b100:  load_val = RED_BCD;
                    3'b010:  load_val = YELLOW_BCD;
                    default: load_val = GREEN_BCD;
                endcase
                // Load wins over a coincident tick; an invalid triple parks the counter at 00.
                cnt_next = cnt_reg;
                if (!valid)
                    cnt_next = 8'h00;
                else if (load)
                    cnt_next = load_val;
                else if (tick && (cnt_reg != 8'h00))
                    cnt_next = bcd_dec(cnt_reg);
            end

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    prev_reg  <= 3'b000;
                    cnt_reg   <= 8'h00;
                    valid_reg <= 1'b0;
                end else begin
                    prev_reg  <= lamps[gi];
                    cnt_reg   <= cnt_next;
                    valid_reg <= valid;
                end
            end

            assign cnt[gi]     = cnt_reg;
            assign valid_q[gi] = valid_reg;
        end
    endgenerate

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [1:0]        idx_reg;
    logic              scan_wrap;

    assign scan_wrap = (scan_cnt_reg == SCAN_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            scan_cnt_reg <= '0;
            idx_reg      <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    // Slot order: dir-1 units, dir-1 tens, dir-2 units, dir-2 tens; zero tens are suppressed.
    logic [3:0] digit;
    logic       blank;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic [3:0] an_reg;
    logic [6:0] seg_reg;

    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        case (idx_reg)
            2'd0: begin
                digit = cnt[0][3:0];
                blank = !valid_q[0];
            end
            2'd1: begin
                digit = cnt[0][7:4];
                blank = !valid_q[0] || (cnt[0][7:4] == 4'd0);
            end
            2'd2: begin
                digit = cnt[1][3:0];
                blank = !valid_q[1];
            end
            2'd3: begin
                digit = cnt[1][7:4];
                blank = !valid_q[1] || (cnt[1][7:4] == 4'd0);
            end
        endcase
        an_next  = blank ? 4'b1111 : ~(4'b0001 << idx_reg);
        seg_next = blank ? 7'b1111111 : seg_of(digit);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'b1111111;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign Cnt1 = cnt[0];
    assign Cnt2 = cnt[1];
    assign AN   = an_reg;
    assign SEG  = seg_reg;

endmodule

// File: tb/tb_light_countdown.sv
// Bench for light_countdown: directed scenarios with literal expectations plus random lamp
// traffic, all checked every cycle against a seconds-level behavioural model.
module tb_light_countdown;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int GS = 12;
    localparam int YS = 3;
    localparam int RS = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red1 = 1'b0, yellow1 = 1'b0, green1 = 1'b0;
    logic       red2 = 1'b0, yellow2 = 1'b0, green2 = 1'b0;
    logic [7:0] cnt1, cnt2;
    logic [3:0] an;
    logic [6:0] seg;

    light_countdown #(
        .TICK_DIV(TD), .SCAN_DIV(SD), .GREEN_SEC(GS), .YELLOW_SEC(YS), .RED_SEC(RS)
    ) dut (
        .CLK(clk), .RST(rst),
        .Red1(red1), .Yellow1(yellow1), .Green1(green1),
        .Red2(red2), .Yellow2(yellow2), .Green2(green2),
        .Cnt1(cnt1), .Cnt2(cnt2), .AN(an), .SEG(seg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: seconds remaining as plain integers, edges counted since reset.
    int         m_n;
    logic [2:0] m_prev [2];
    int         m_val  [2];
    bit         m_ok   [2];
    bit         m_live = 1'b0;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic [2:0] m_cur  [2];
    bit         m_tick;

    function automatic int secs_of(input logic [2:0] t);
        case (t)
            3'b100:  return RS;
            3'b010:  return YS;
            3'b001:  return GS;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_display(input int idx);
        int d;
        int digit;
        bit tens;
        d     = idx / 2;
        tens  = (idx % 2) == 1;
        digit = tens ? m_val[d] / 10 : m_val[d] % 10;
        if (!m_ok[d] || (tens && digit == 0)) begin
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
        end else begin
            m_an  = ~(4'(1) << idx);
            m_seg = seg7(digit);
        end
    endtask

    // Model update plus the per-cycle compare, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            m_cur[0] = {red1, yellow1, green1};
            m_cur[1] = {red2, yellow2, green2};
            if (!rst) begin
                m_live = 1'b1;
                m_n    = 0;
                m_an   = 4'b1111;
                m_seg  = 7'b1111111;
                for (int d = 0; d < 2; d++) begin
                    m_prev[d] = 3'b000;
                    m_val[d]  = 0;
                    m_ok[d]   = 1'b0;
                end
            end else if (m_live) begin
                model_display((m_n / SD) % 4);
                m_tick = (m_n % TD) == TD - 1;
                for (int d = 0; d < 2; d++) begin
                    if ($countones(m_cur[d]) != 1) begin
                        m_val[d] = 0;
                        m_ok[d]  = 1'b0;
                    end else begin
                        if (m_cur[d] != m_prev[d])
                            m_val[d] = secs_of(m_cur[d]);
                        else if (m_tick && m_val[d] > 0)
                            m_val[d] = m_val[d] - 1;
                        m_ok[d] = 1'b1;
                    end
                    m_prev[d] = m_cur[d];
                end
                m_n++;
            end
            #1;
            if (m_live) begin
                check("model_cnt1", cnt1, bcd(m_val[0]));
                check("model_cnt2", cnt2, bcd(m_val[1]));
                check("model_an", an, m_an);
                check("model_seg", seg, m_seg);
            end
        end
    end

    logic [7:0] seen [$];
    int         n_a, n_b, n_c;
    int         dir;
    logic [2:0] pat;

    initial begin
        repeat (3) @(negedge clk);

        rst = 1'b1; green1 = 1'b1; red2 = 1'b1;
        $display("txn: release reset, Green1 + Red2");
        @(negedge clk);
        check("load_green1", cnt1, 8'h12);
        check("load_red2", cnt2, 8'h10);
        repeat (11) @(negedge clk);
        check("three_ticks_cnt1", cnt1, 8'h09);
        check("three_ticks_cnt2", cnt2, 8'h07);

        green1 = 1'b0; yellow1 = 1'b1;
        $display("txn: Yellow1 held through saturation");
        @(negedge clk);
        seen.delete();
        seen.push_back(cnt1);
        repeat (20) begin
            @(negedge clk);
            if (cnt1 != seen[$]) seen.push_back(cnt1);
        end
        check("yellow_steps", seen.size(), 4);
        if (seen.size() == 4) begin
            check("yellow_0", seen[0], 8'h03);
            check("yellow_1", seen[1], 8'h02);
            check("yellow_2", seen[2], 8'h01);
            check("yellow_3", seen[3], 8'h00);
        end
        check("yellow_hold", cnt1, 8'h00);

        $display("txn: scan sweep with Cnt1=00");
        n_a = 0; n_b = 0;
        repeat (8) begin
            @(negedge clk);
            if (an == 4'b1110 && seg == 7'b1000000) n_a++;
            if (an == 4'b1101) n_b++;
        end
        check("scan_units_zero", n_a, 2);
        check("scan_tens_blank", n_b, 0);

        for (int i = 0; i < 8 && (m_n % TD) != TD - 1; i++) @(negedge clk);
        yellow1 = 1'b0; red1 = 1'b1;
        $display("txn: Red1 on a tick edge");
        @(negedge clk);
        check("load_over_tick", cnt1, 8'h10);
        repeat (3) @(negedge clk);
        check("red_before_tick", cnt1, 8'h10);
        @(negedge clk);
        check("red_after_tick", cnt1, 8'h09);

        red1 = 1'b0;
        $display("txn: direction-1 triple 000 then 110");
        @(negedge clk);
        check("invalid_000", cnt1, 8'h00);
        red1 = 1'b1; yellow1 = 1'b1;
        n_c = 0;
        repeat (8) begin
            @(negedge clk);
            if (an == 4'b1110 || an == 4'b1101) n_c++;
        end
        check("invalid_blank", n_c, 0);
        check("invalid_110", cnt1, 8'h00);
        red1 = 1'b0; yellow1 = 1'b0; green1 = 1'b1;
        $display("txn: Green1 after invalid");
        @(negedge clk);
        check("reload_green1", cnt1, 8'h12);

        repeat (5) @(negedge clk);
        rst = 1'b0;
        $display("txn: one-cycle reset mid-countdown");
        @(negedge clk);
        check("rst_cnt1", cnt1, 8'h00);
        check("rst_cnt2", cnt2, 8'h00);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        rst = 1'b1;
        @(negedge clk);
        check("rst_reload1", cnt1, 8'h12);
        check("rst_reload2", cnt2, 8'h10);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                dir = int'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 7)
                    pat = 3'b001 << $urandom_range(0, 2);
                else
                    pat = 3'($urandom_range(0, 7));
                if (dir == 0) {red1, yellow1, green1} = pat;
                else          {red2, yellow2, green2} = pat;
                $display("txn: random dir%0d lamps=%b rst=%b", dir + 1, pat, rst);
            end
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_countdown.md
LIGHT_COUNTDOWN -- requirements
Module: light_countdown

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- TICK_DIV, 100000000, CLK cycles per 1 s tick.
- SCAN_DIV, 100000, CLK cycles per display digit slot.
- GREEN_SEC, 25, green phase seconds, 1..99.
- YELLOW_SEC, 5, yellow phase seconds, 1..99.
- RED_SEC, 30, red phase seconds, 1..99.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- CLK, in, 1, single clock; all logic on its rising edge.
- RST, in, 1, reset: synchronous and active-low.
- Red1 / Yellow1 / Green1, in, 1 each, direction-1 lamps, driven by the traffic controller.
- Red2 / Yellow2 / Green2, in, 1 each, direction-2 lamps.
- Cnt1, out, 8, direction-1 remaining seconds as BCD {tens, units}.
- Cnt2, out, 8, direction-2 remaining seconds as BCD.
- AN, out, 4, digit enables, active-low.
- SEG, out, 7, segments {g,f,e,d,c,b,a}, active-low; SEG[0]=a.

Function
REQ-003 A lamp triple SHALL be valid only when exactly one of R/Y/G is 1; any other pattern is invalid.
REQ-004 Each direction SHALL register its previous triple every cycle; a load SHALL occur when the current triple is valid and differs from the previous one.
REQ-005 On a load, the counter SHALL take the BCD of RED_SEC, YELLOW_SEC or GREEN_SEC for the new colour, visible on Cnt one cycle after the input change.
REQ-006 The tick counter SHALL run free from 0 to TICK_DIV-1 and wrap; tick SHALL be a one-cycle pulse at TICK_DIV-1.
- The tick counter is not realigned on a load, so the first second after a load may be short.
REQ-007 On tick without a load, a counter greater than 00 SHALL decrement in BCD: units 0 becomes 9 with tens-1, otherwise units-1.
- At 00 the counter SHALL saturate and hold until the next load.
REQ-008 A load and a tick in the same cycle SHALL apply only the load.
REQ-009 While a direction's triple is invalid, its counter SHALL hold 00 and its two digits SHALL be blanked.
- Its previous triple SHALL still be registered, so the next valid triple loads.
REQ-010 Directions SHALL be independent; simultaneous loads on both SHALL both take effect.
REQ-011 The scan counter SHALL run 0 to SCAN_DIV-1; at its wrap, the digit index SHALL advance 0,1,2,3,0.
- Index 0: Cnt1 units on AN[0]. Index 1: Cnt1 tens on AN[1]. Index 2: Cnt2 units on AN[2]. Index 3: Cnt2 tens on AN[3].
REQ-012 Exactly one AN bit SHALL be low at a time, except that a blanked digit SHALL drive AN=1111 and SEG=1111111 for its slot.
REQ-013 A tens digit of 0 SHALL be blanked (leading-zero suppression); units SHALL always show while the direction is valid.
REQ-014 SEG SHALL use standard active-low 7-segment encoding for digits 0-9, e.g. 0=1000000, 1=1111001, 5=0010010, 9=0010000.
REQ-015 AN and SEG SHALL be registered, changing one cycle after the digit index or counter changes.

Reset
REQ-016 When RST=0 at a CLK edge, the block SHALL set:
- Cnt1=Cnt2=8'h00, AN=1111, SEG=1111111.
- Tick counter, scan counter and digit index to 0.
- Both previous triples to 000.
REQ-017 Reset SHALL take priority over load, tick and scan, including mid-countdown.
REQ-018 The first valid triple after reset release SHALL cause a load.

Verification
Bench parameters: TICK_DIV=4, SCAN_DIV=2, GREEN_SEC=12, YELLOW_SEC=3, RED_SEC=10.
REQ-019 Release reset, then apply Green1=1, Red2=1 -> next cycle Cnt1=8'h12 and Cnt2=8'h10; after 3 ticks Cnt1=8'h09 and Cnt2=8'h07.
REQ-020 Hold Yellow1 beyond 3 ticks -> Cnt1 goes 03, 02, 01, 00, then stays 00 on later ticks.
REQ-021 Change Yellow1 to Red1 in the same cycle as a tick -> Cnt1=8'h10, with no decrement that cycle.
REQ-022 Apply direction-1 triple 000, then 110 -> Cnt1=00 and both direction-1 digit slots show AN=1111; then Green1 alone -> Cnt1=8'h12.
REQ-023 With Cnt1=8'h05 and Cnt2=8'h10 -> the scan shows in order: AN=1110 with SEG=0010010, then a blank slot, then AN=1011 with SEG=1000000, then AN=0111 with SEG=1111001.
REQ-024 Pull RST low mid-countdown for one cycle -> all outputs return to reset values; the next valid triples reload.
